// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: request/response bundle between the core and muldiv_unit.
//   master (core side): drives start, funct3, op_a, op_b, rd_in;
//                       observes busy, done, we, result, rd_out.
//   slave  (unit side): the mirror image.
interface muldiv_unit_if #(
  parameter int D_WIDTH = 32,
  parameter int A_WIDTH = 5
);
  logic               start;
  logic [2:0]         funct3;
  logic [D_WIDTH-1:0] op_a;
  logic [D_WIDTH-1:0] op_b;
  logic [A_WIDTH-1:0] rd_in;
  logic               busy;
  logic               done;
  logic               we;
  logic [D_WIDTH-1:0] result;
  logic [A_WIDTH-1:0] rd_out;

  modport master (
    output start, funct3, op_a, op_b, rd_in,
    input  busy, done, we, result, rd_out
  );

  modport slave (
    input  start, funct3, op_a, op_b, rd_in,
    output busy, done, we, result, rd_out
  );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide, one bit per cycle.
//   clk, rst   : rising-edge clock, asynchronous active-high reset
//   bus.start  : request, sampled only while idle
//   bus.funct3 : MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU
//   bus.op_a/b : rs1/rs2 values, latched at the accepting edge
//   bus.rd_in  : destination register, returned on rd_out
//   bus.busy   : high whenever not idle
//   bus.done   : one-cycle result pulse; bus.we = done unless rd_out==0
//   bus.result : held until the next completion
// Signed operands are reduced to magnitudes, the unsigned core runs for
// D_WIDTH iterations, and the sign is applied when the result is latched.
module muldiv_unit #(
  parameter int D_WIDTH = 32,
  parameter int A_WIDTH = 5
) (
  input logic            clk,
  input logic            rst,
  muldiv_unit_if.slave   bus
);

  localparam int C_WIDTH = $clog2(D_WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t               state, state_next;
  logic [C_WIDTH-1:0]   count;
  logic [2:0]           op;
  logic                 neg;
  logic [D_WIDTH-1:0]   mag;
  logic [D_WIDTH-1:0]   acc_hi, acc_lo;
  logic [D_WIDTH-1:0]   result_r;
  logic [A_WIDTH-1:0]   rd_r;

  // Request decode (only meaningful while idle)
  logic                 is_div, sgn_a, sgn_b, neg_c, special;
  logic [D_WIDTH-1:0]   abs_a, abs_b, special_res;

  always_comb begin
    is_div = bus.funct3[2];
    sgn_a  = (bus.funct3 == 3'b001 || bus.funct3 == 3'b010 ||
              bus.funct3 == 3'b100 || bus.funct3 == 3'b110) && bus.op_a[D_WIDTH-1];
    sgn_b  = (bus.funct3 == 3'b001 || bus.funct3 == 3'b100 ||
              bus.funct3 == 3'b110) && bus.op_b[D_WIDTH-1];
    abs_a  = sgn_a ? -bus.op_a : bus.op_a;
    abs_b  = sgn_b ? -bus.op_b : bus.op_b;
    // Remainder follows the dividend's sign; products and quotients the XOR.
    neg_c  = (is_div && bus.funct3[1]) ? sgn_a : (sgn_a ^ sgn_b);
    special     = 1'b0;
    special_res = '0;
    if (is_div && bus.op_b == '0) begin
      special     = 1'b1;
      special_res = bus.funct3[1] ? bus.op_a : '1;
    end else if (is_div && !bus.funct3[0] && bus.op_b == '1 &&
                 bus.op_a == {1'b1, {(D_WIDTH-1){1'b0}}}) begin
      special     = 1'b1;
      // Overflow quotient equals the dividend itself; remainder is zero.
      special_res = bus.funct3[1] ? '0 : bus.op_a;
    end
  end

  // One iteration of the shared core: acc_hi:acc_lo is the product being
  // shifted right (multiply) or remainder:quotient shifted left (divide).
  logic [D_WIDTH-1:0]   addend;
  logic [D_WIDTH:0]     sum;
  logic [D_WIDTH:0]     shifted;
  logic                 fits;
  logic [D_WIDTH-1:0]   sub;
  logic [D_WIDTH-1:0]   hi_n, lo_n;
  logic [2*D_WIDTH-1:0] prod;
  logic [D_WIDTH-1:0]   div_val;
  logic [D_WIDTH-1:0]   fin;

  always_comb begin
    addend  = acc_lo[0] ? mag : '0;
    sum     = {1'b0, acc_hi} + {1'b0, addend};
    shifted = {acc_hi, acc_lo[D_WIDTH-1]};
    fits    = shifted >= {1'b0, mag};
    sub     = shifted[D_WIDTH-1:0] - mag;
    if (op[2]) begin
      hi_n = fits ? sub : shifted[D_WIDTH-1:0];
      lo_n = {acc_lo[D_WIDTH-2:0], fits};
    end else begin
      hi_n = sum[D_WIDTH:1];
      lo_n = {sum[0], acc_lo[D_WIDTH-1:1]};
    end
    prod    = neg ? -{hi_n, lo_n} : {hi_n, lo_n};
    div_val = op[1] ? hi_n : lo_n;
    if (op[2])
      fin = neg ? -div_val : div_val;
    else if (op[1:0] == 2'b00)
      fin = prod[D_WIDTH-1:0];
    else
      fin = prod[2*D_WIDTH-1:D_WIDTH];
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = special ? DONE : CALC;
      CALC:    if (count == '1) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count    <= '0;
      op       <= '0;
      neg      <= 1'b0;
      mag      <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      result_r <= '0;
      rd_r     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            op     <= bus.funct3;
            rd_r   <= bus.rd_in;
            neg    <= neg_c;
            count  <= '0;
            acc_hi <= '0;
            acc_lo <= is_div ? abs_a : abs_b;
            mag    <= is_div ? abs_b : abs_a;
            if (special) result_r <= special_res;
          end
        end
        CALC: begin
          count  <= count + 1'b1;
          acc_hi <= hi_n;
          acc_lo <= lo_n;
          if (count == '1) result_r <= fin;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy   = (state != IDLE);
  assign bus.done   = (state == DONE);
  assign bus.we     = (state == DONE) && (rd_r != '0);
  assign bus.result = result_r;
  assign bus.rd_out = rd_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: randomized and directed checks of muldiv_unit against a
// plain-arithmetic RV32M reference, with a queue-based scoreboard.
module tb_muldiv_unit;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  muldiv_unit_if #(.D_WIDTH(32), .A_WIDTH(5)) bus ();

  muldiv_unit #(.D_WIDTH(32), .A_WIDTH(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        we;
    int unsigned due;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  int unsigned cyc = 0;
  logic [31:0] held = '0;

  always @(posedge clk) cyc++;

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit is_special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (!f[2]) return 1'b0;
    if (b == 32'd0) return 1'b1;
    return (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    int x, y;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    x = a;
    y = b;
    case (f)
      3'b000: begin p = ua * ub; return p[31:0];  end
      3'b001: begin p = sa * sb; return p[63:32]; end
      3'b010: begin p = sa * ub; return p[63:32]; end
      3'b011: begin p = ua * ub; return p[63:32]; end
      3'b100: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return x / y;
      end
      3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return x % y;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Monitor: compares every done pulse with the oldest expectation, and
  // checks busy/result-hold behaviour on the cycles in between.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      held = '0;
    end else if (bus.done) begin
      if (sb.size() == 0) begin
        chk(1'b0, "spurious_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk(bus.result === e.res, "result", bus.result, e.res);
        chk(bus.rd_out === e.rd, "rd_out", 32'(bus.rd_out), 32'(e.rd));
        chk(bus.we === e.we, "we", 32'(bus.we), 32'(e.we));
        chk(cyc == e.due, "latency", cyc, e.due);
        chk(bus.busy === 1'b1, "busy_in_done", 32'(bus.busy), 32'd1);
        held = e.res;
      end
    end else begin
      chk(bus.result === held, "result_hold", bus.result, held);
      if (sb.size() != 0) chk(bus.busy === 1'b1, "busy_calc", 32'(bus.busy), 32'd1);
      else                chk(bus.busy === 1'b0, "busy_idle", 32'(bus.busy), 32'd0);
    end
  end

  task automatic drain();
    int unsigned n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk(1'b0, "done_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input bit wait_done);
    int unsigned n = 0;
    exp_t e;
    @(negedge clk);
    while (bus.busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (bus.busy) begin
      chk(1'b0, "idle_timeout", 32'd1, 32'd0);
      return;
    end
    bus.funct3 = f;
    bus.op_a   = a;
    bus.op_b   = b;
    bus.rd_in  = rd;
    bus.start  = 1'b1;
    @(posedge clk);
    #1;
    // Scramble the inputs: the unit must work from its latched copies.
    bus.start  = 1'b0;
    bus.funct3 = 3'($urandom);
    bus.op_a   = $urandom;
    bus.op_b   = $urandom;
    bus.rd_in  = 5'($urandom);
    e.res = model(f, a, b);
    e.rd  = rd;
    e.we  = (rd != 5'd0);
    e.due = cyc + (is_special(f, a, b) ? 0 : 32);
    sb.push_back(e);
    if (wait_done) drain();
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(5, 0))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return $urandom_range(20, 0);
      default: return $urandom;
    endcase
  endfunction

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
  } vec_t;

  vec_t dir[$];

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    bus.start  = 1'b0;
    bus.funct3 = '0;
    bus.op_a   = '0;
    bus.op_b   = '0;
    bus.rd_in  = '0;
    #2 rst = 1'b1;
    #1;
    chk(bus.busy === 1'b0, "rst_busy", 32'(bus.busy), 32'd0);
    chk(bus.done === 1'b0, "rst_done", 32'(bus.done), 32'd0);
    chk(bus.we === 1'b0, "rst_we", 32'(bus.we), 32'd0);
    chk(bus.result === 32'd0, "rst_result", bus.result, 32'd0);
    chk(bus.rd_out === 5'd0, "rst_rd_out", 32'(bus.rd_out), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    dir.push_back('{3'b000, 32'd7, 32'hFFFF_FFFD});
    dir.push_back('{3'b001, 32'h8000_0000, 32'h8000_0000});
    dir.push_back('{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF});
    dir.push_back('{3'b010, 32'hFFFF_FFFF, 32'd2});
    dir.push_back('{3'b100, 32'hFFFF_FFF9, 32'd2});
    dir.push_back('{3'b110, 32'hFFFF_FFF9, 32'd2});
    dir.push_back('{3'b101, 32'd100, 32'd7});
    dir.push_back('{3'b111, 32'd100, 32'd7});
    dir.push_back('{3'b101, 32'd5, 32'd0});
    dir.push_back('{3'b110, 32'd5, 32'd0});
    dir.push_back('{3'b100, 32'h8000_0000, 32'hFFFF_FFFF});
    dir.push_back('{3'b110, 32'h8000_0000, 32'hFFFF_FFFF});
    dir.push_back('{3'b111, 32'h8000_0000, 32'hFFFF_FFFF});
    foreach (dir[i]) issue(dir[i].f, dir[i].a, dir[i].b, 5'd1 + 5'(i), 1'b1);

    // Write-enable suppression for x0
    issue(3'b000, 32'd3, 32'd4, 5'd0, 1'b1);
    issue(3'b000, 32'd3, 32'd4, 5'd5, 1'b1);

    // A start pulse mid-calculation must not disturb the running op
    issue(3'b100, 32'd1000, 32'd9, 5'd7, 1'b0);
    repeat (5) @(negedge clk);
    bus.funct3 = 3'b000;
    bus.op_a   = 32'd123;
    bus.op_b   = 32'd456;
    bus.rd_in  = 5'd9;
    bus.start  = 1'b1;
    @(negedge clk);
    bus.start  = 1'b0;
    drain();

    // Asynchronous reset in the middle of iteration 10
    issue(3'b011, 32'hDEAD_BEEF, 32'h1234_5678, 5'd3, 1'b0);
    repeat (10) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    sb.delete();
    chk(bus.busy === 1'b0, "arst_busy", 32'(bus.busy), 32'd0);
    chk(bus.done === 1'b0, "arst_done", 32'(bus.done), 32'd0);
    chk(bus.result === 32'd0, "arst_result", bus.result, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    issue(3'b001, 32'hFFFF_FFFE, 32'd3, 5'd4, 1'b1);

    // Randomized operations
    for (int i = 0; i < 40; i++)
      issue(3'($urandom), pick(), pick(), 5'($urandom), 1'b1);

    drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
